// File: rtl/fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl
// Control sequencer for an in-place radix-2 DIT FFT. It walks all N_LOG2
// stages and, for each butterfly, issues the data-RAM read pair (a, b) and the
// twiddle-ROM index. Between stages it drains the pipeline so the last
// write-back of a stage lands before the next stage reads the same RAM.
// It also generates the butterfly enable and the write-back strobe/addresses
// through plain shift registers that match the RAM and butterfly latencies.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      one-cycle request to run a full FFT (ignored unless idle)
//   busy       high from the first read cycle until the cycle before done
//   done       one-cycle completion pulse
//   stage      current stage 1..N_LOG2, 0 while idle or done
//   rd_en      data-RAM read strobe
//   rd_addr_a  read address of butterfly input a
//   rd_addr_b  read address of butterfly input b
//   tw_addr    twiddle-ROM index k of W_N^k
//   bf_en      butterfly enable (rd_en delayed RAM_RD_LAT)
//   wr_en      data-RAM write strobe (bf_en delayed BF_LAT)
//   wr_addr_a  write address for butterfly output a
//   wr_addr_b  write address for butterfly output b
// -----------------------------------------------------------------------------
module fft_stage_ctrl #(
   parameter int N_LOG2     = 8,
   parameter int RAM_RD_LAT = 1,
   parameter int BF_LAT     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(N_LOG2+1)-1:0]  stage,
   output logic                         rd_en,
   output logic [N_LOG2-1:0]            rd_addr_a,
   output logic [N_LOG2-1:0]            rd_addr_b,
   output logic [N_LOG2-2:0]            tw_addr,
   output logic                         bf_en,
   output logic                         wr_en,
   output logic [N_LOG2-1:0]            wr_addr_a,
   output logic [N_LOG2-1:0]            wr_addr_b
);

   localparam int SW        = $clog2(N_LOG2 + 1);
   localparam int TW_W      = N_LOG2 - 1;
   localparam int DRAIN_LEN = RAM_RD_LAT + BF_LAT + 1;
   localparam int DW        = $clog2(DRAIN_LEN);
   localparam int WB_LAT    = RAM_RD_LAT + BF_LAT;

   localparam logic [N_LOG2-1:0] ZERO_A     = {N_LOG2{1'b0}};
   localparam logic [N_LOG2-1:0] ONE_A      = N_LOG2'(1);
   localparam logic [N_LOG2-1:0] K_LAST     = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
   localparam logic [SW-1:0]     ZERO_S     = {SW{1'b0}};
   localparam logic [SW-1:0]     ONE_S      = SW'(1);
   localparam logic [SW-1:0]     LAST_STAGE = SW'(N_LOG2);
   localparam logic [DW-1:0]     ZERO_D     = {DW{1'b0}};
   localparam logic [DW-1:0]     ONE_D      = DW'(1);
   localparam logic [DW-1:0]     D_LAST     = DW'(DRAIN_LEN - 1);
   localparam logic [TW_W-1:0]   ZERO_T     = {TW_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [N_LOG2-1:0] k_r, k_s;
   logic [SW-1:0]     stage_r, stage_s;
   logic [DW-1:0]     drain_r, drain_s;

   logic              rd_en_r, busy_r, done_r;
   logic [N_LOG2-1:0] rd_addr_a_r, rd_addr_b_r;
   logic [TW_W-1:0]   tw_addr_r;

   logic [RAM_RD_LAT-1:0] bf_pipe_r;
   logic [BF_LAT-1:0]     wr_pipe_r;
   logic [N_LOG2-1:0]     wa_pipe_r [WB_LAT];
   logic [N_LOG2-1:0]     wb_pipe_r [WB_LAT];

   // half - 1 for stage l, i.e. the mask selecting j = k mod half
   function automatic logic [N_LOG2-1:0] half_mask_f(input logic [SW-1:0] l);
      return (ONE_A << (l - ONE_S)) - ONE_A;
   endfunction

   // Address a: insert a zero bit at position l-1 of k (= 2*half*g + j)
   function automatic logic [N_LOG2-1:0] addr_a_f(input logic [N_LOG2-1:0] k,
                                                  input logic [SW-1:0]     l);
      return ((k >> (l - ONE_S)) << l) | (k & half_mask_f(l));
   endfunction

   // Twiddle index: j scaled to the full-length ROM, j << (N_LOG2 - l)
   function automatic logic [TW_W-1:0] tw_f(input logic [N_LOG2-1:0] k,
                                            input logic [SW-1:0]     l);
      logic [N_LOG2-1:0] sh;
      sh = (k & half_mask_f(l)) << (LAST_STAGE - l);
      return sh[TW_W-1:0];
   endfunction

   // FSM state, butterfly counter, stage and drain counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         k_r     <= ZERO_A;
         stage_r <= ZERO_S;
         drain_r <= ZERO_D;
      end else begin
         state_r <= state_s;
         k_r     <= k_s;
         stage_r <= stage_s;
         drain_r <= drain_s;
      end
   end

   // Next-state logic for the stage walker
   always_comb begin
      state_s = state_r;
      k_s     = k_r;
      stage_s = stage_r;
      drain_s = drain_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
               k_s     = ZERO_A;
               stage_s = ONE_S;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (k_r == K_LAST) begin
               state_s = DRAIN;
               drain_s = ZERO_D;
            end else begin
               k_s = k_r + ONE_A;
            end
         end
         DRAIN: begin
            if (drain_r == D_LAST) begin
               if (stage_r < LAST_STAGE) begin
                  state_s = RUN;
                  stage_s = stage_r + ONE_S;
                  k_s     = ZERO_A;
               end else begin
                  state_s = DONE;
                  stage_s = ZERO_S;
               end
            end else begin
               drain_s = drain_r + ONE_D;
            end
         end
         DONE: begin
            state_s = IDLE;
            stage_s = ZERO_S;
         end
         default: begin
            state_s = IDLE;
            k_s     = ZERO_A;
            stage_s = ZERO_S;
            drain_s = ZERO_D;
         end
      endcase
   end

   // Registered read strobe, addresses and status, decoded from the next state
   // so they are valid in the same cycle the FSM sits in RUN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_en_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         rd_addr_a_r <= ZERO_A;
         rd_addr_b_r <= ZERO_A;
         tw_addr_r   <= ZERO_T;
      end else begin
         rd_en_r <= (state_s == RUN);
         busy_r  <= (state_s == RUN) || (state_s == DRAIN);
         done_r  <= (state_s == DONE);
         if (state_s == RUN) begin
            rd_addr_a_r <= addr_a_f(k_s, stage_s);
            rd_addr_b_r <= addr_a_f(k_s, stage_s) | (ONE_A << (stage_s - ONE_S));
            tw_addr_r   <= tw_f(k_s, stage_s);
         end else begin
            rd_addr_a_r <= ZERO_A;
            rd_addr_b_r <= ZERO_A;
            tw_addr_r   <= ZERO_T;
         end
      end
   end

   // Latency-matching shift registers, independent of the FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bf_pipe_r <= {RAM_RD_LAT{1'b0}};
         wr_pipe_r <= {BF_LAT{1'b0}};
         for (int i = 0; i < WB_LAT; i++) begin
            wa_pipe_r[i] <= ZERO_A;
            wb_pipe_r[i] <= ZERO_A;
         end
      end else begin
         bf_pipe_r[0] <= rd_en_r;
         for (int i = 1; i < RAM_RD_LAT; i++) begin
            bf_pipe_r[i] <= bf_pipe_r[i-1];
         end
         wr_pipe_r[0] <= bf_pipe_r[RAM_RD_LAT-1];
         for (int i = 1; i < BF_LAT; i++) begin
            wr_pipe_r[i] <= wr_pipe_r[i-1];
         end
         wa_pipe_r[0] <= rd_addr_a_r;
         wb_pipe_r[0] <= rd_addr_b_r;
         for (int i = 1; i < WB_LAT; i++) begin
            wa_pipe_r[i] <= wa_pipe_r[i-1];
            wb_pipe_r[i] <= wb_pipe_r[i-1];
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign stage     = stage_r;
   assign rd_en     = rd_en_r;
   assign rd_addr_a = rd_addr_a_r;
   assign rd_addr_b = rd_addr_b_r;
   assign tw_addr   = tw_addr_r;
   assign bf_en     = bf_pipe_r[RAM_RD_LAT-1];
   assign wr_en     = wr_pipe_r[BF_LAT-1];
   assign wr_addr_a = wa_pipe_r[WB_LAT-1];
   assign wr_addr_b = wb_pipe_r[WB_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_ctrl
// Scoreboard bench for fft_stage_ctrl. Stimulus pushes expected read, enable,
// write-back and done events (with their cycle numbers) into queues; monitor
// processes pop and compare whenever a DUT strobe is seen. Two instances:
// N_LOG2=3 with default latencies (hand tables) and N_LOG2=8 with
// RAM_RD_LAT=2 (nested-loop reference).
// -----------------------------------------------------------------------------
module tb_fft_stage_ctrl;

   typedef struct {
      int cyc;
      int a;
      int b;
      int tw;
      int st;
   } ev_t;

   logic clk    = 1'b0;
   logic rst    = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   logic       busy1, done1, rd_en1, bf_en1, wr_en1;
   logic [1:0] stage1, tw1;
   logic [2:0] ra1, rb1, wa1, wb1;

   logic       busy2, done2, rd_en2, bf_en2, wr_en2;
   logic [3:0] stage2;
   logic [6:0] tw2;
   logic [7:0] ra2, rb2, wa2, wb2;

   logic [20:0] out1;
   logic [47:0] out2;
   assign out1 = {busy1, done1, stage1, rd_en1, ra1, rb1, tw1, bf_en1, wr_en1, wa1, wb1};
   assign out2 = {busy2, done2, stage2, rd_en2, ra2, rb2, tw2, bf_en2, wr_en2, wa2, wb2};

   int edge_cnt = 0;
   int n_cmp    = 0;
   int n_bad    = 0;
   int busy_lo  = 1;
   int busy_hi  = 0;

   ev_t rd_q[$], bf_q[$], wr_q[$], dn_q[$];
   ev_t rd2_q[$], wr2_q[$], dn2_q[$];

   // Hand-computed N=8 read pairs and twiddles, stages 1..3
   int tab_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int tab_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   fft_stage_ctrl #(.N_LOG2(3), .RAM_RD_LAT(1), .BF_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .stage(stage1), .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1),
      .tw_addr(tw1), .bf_en(bf_en1), .wr_en(wr_en1),
      .wr_addr_a(wa1), .wr_addr_b(wb1)
   );

   fft_stage_ctrl #(.N_LOG2(8), .RAM_RD_LAT(2), .BF_LAT(3)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
      .stage(stage2), .rd_en(rd_en2), .rd_addr_a(ra2), .rd_addr_b(rb2),
      .tw_addr(tw2), .bf_en(bf_en2), .wr_en(wr_en2),
      .wr_addr_a(wa2), .wr_addr_b(wb2)
   );

   always #5 clk = ~clk;

   // Cycle number: at the negedge of cycle c, edge_cnt == c
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic ok, input string act, input string req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s @%0d: got %s, want %s", nm, edge_cnt, act, req);
      end
   endtask

   // Monitor for the N=8 instance
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         chk("busy", busy1 == (edge_cnt >= busy_lo && edge_cnt <= busy_hi),
             $sformatf("%0b", busy1), $sformatf("%0b", edge_cnt >= busy_lo && edge_cnt <= busy_hi));
         if (rd_en1) begin
            chk("rd_expected", rd_q.size() != 0, $sformatf("read (%0d,%0d)", ra1, rb1), "no read");
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               chk("rd", edge_cnt == e.cyc && int'(ra1) == e.a && int'(rb1) == e.b &&
                   int'(tw1) == e.tw && int'(stage1) == e.st,
                   $sformatf("c%0d (%0d,%0d) tw%0d L%0d", edge_cnt, ra1, rb1, tw1, stage1),
                   $sformatf("c%0d (%0d,%0d) tw%0d L%0d", e.cyc, e.a, e.b, e.tw, e.st));
            end
         end
         if (bf_en1) begin
            chk("bf_expected", bf_q.size() != 0, "bf_en=1", "bf_en=0");
            if (bf_q.size() != 0) begin
               e = bf_q.pop_front();
               chk("bf_cycle", edge_cnt == e.cyc, $sformatf("%0d", edge_cnt), $sformatf("%0d", e.cyc));
            end
         end
         if (wr_en1) begin
            chk("wr_expected", wr_q.size() != 0, $sformatf("write (%0d,%0d)", wa1, wb1), "no write");
            chk("wr_rd_overlap", rd_en1 == 1'b0, $sformatf("rd_en=%0b", rd_en1), "rd_en=0");
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               chk("wr", edge_cnt == e.cyc && int'(wa1) == e.a && int'(wb1) == e.b,
                   $sformatf("c%0d (%0d,%0d)", edge_cnt, wa1, wb1),
                   $sformatf("c%0d (%0d,%0d)", e.cyc, e.a, e.b));
            end
         end
         if (done1) begin
            chk("done_expected", dn_q.size() != 0, "done=1", "done=0");
            if (dn_q.size() != 0) begin
               e = dn_q.pop_front();
               chk("done_cycle", edge_cnt == e.cyc, $sformatf("%0d", edge_cnt), $sformatf("%0d", e.cyc));
            end
         end
      end
   end

   // Monitor for the N=256 instance
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rd_en2) begin
            chk("rd2_expected", rd2_q.size() != 0, $sformatf("read (%0d,%0d)", ra2, rb2), "no read");
            if (rd2_q.size() != 0) begin
               e = rd2_q.pop_front();
               chk("rd2", edge_cnt == e.cyc && int'(ra2) == e.a && int'(rb2) == e.b &&
                   int'(tw2) == e.tw && int'(stage2) == e.st,
                   $sformatf("c%0d (%0d,%0d) tw%0d L%0d", edge_cnt, ra2, rb2, tw2, stage2),
                   $sformatf("c%0d (%0d,%0d) tw%0d L%0d", e.cyc, e.a, e.b, e.tw, e.st));
            end
         end
         if (wr_en2) begin
            chk("wr2_expected", wr2_q.size() != 0, $sformatf("write (%0d,%0d)", wa2, wb2), "no write");
            if (wr2_q.size() != 0) begin
               e = wr2_q.pop_front();
               chk("wr2", edge_cnt == e.cyc && int'(wa2) == e.a && int'(wb2) == e.b,
                   $sformatf("c%0d (%0d,%0d)", edge_cnt, wa2, wb2),
                   $sformatf("c%0d (%0d,%0d)", e.cyc, e.a, e.b));
            end
         end
         if (done2) begin
            chk("done2_expected", dn2_q.size() != 0, "done=1", "done=0");
            if (dn2_q.size() != 0) begin
               e = dn2_q.pop_front();
               chk("done2_cycle", edge_cnt == e.cyc, $sformatf("%0d", edge_cnt), $sformatf("%0d", e.cyc));
            end
         end
      end
   end

   // Advance to the first negedge whose cycle number is >= t
   task automatic goto_neg(input int t);
      @(negedge clk);
      for (int i = 0; i < 5000 && edge_cnt < t; i++) @(negedge clk);
   endtask

   // Expected events of one N=8 run whose cycle 1 is cycle s
   task automatic push_nominal(input int s);
      for (int st = 0; st < 3; st++) begin
         for (int i = 0; i < 4; i++) begin
            int rc;
            int ix;
            ix = st * 4 + i;
            rc = s + st * 9 + i;
            rd_q.push_back('{rc, tab_a[ix], tab_b[ix], tab_tw[ix], st + 1});
            bf_q.push_back('{rc + 1, 0, 0, 0, 0});
            wr_q.push_back('{rc + 4, tab_a[ix], tab_b[ix], 0, 0});
         end
      end
      dn_q.push_back('{s + 27, 0, 0, 0, 0});
      busy_lo = s;
      busy_hi = s + 26;
   endtask

   // Call at a negedge: pulse start1, return s = cycle number of cycle 1
   task automatic launch1(output int s);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      s = edge_cnt;
      start1 = 1'b0;
      push_nominal(s);
   endtask

   task automatic pulse1;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
   endtask

   task automatic drained(input string nm);
      chk(nm, rd_q.size() == 0 && bf_q.size() == 0 && wr_q.size() == 0 && dn_q.size() == 0 &&
          rd2_q.size() == 0 && wr2_q.size() == 0 && dn2_q.size() == 0,
          $sformatf("left rd%0d bf%0d wr%0d dn%0d rd2_%0d wr2_%0d dn2_%0d", rd_q.size(), bf_q.size(),
                    wr_q.size(), dn_q.size(), rd2_q.size(), wr2_q.size(), dn2_q.size()),
          "all expected events seen");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      int s0;
      int s1;
      int s2;
      int idx;
      int half;
      int grp;

      // Reset with start pulses applied while held in reset
      repeat (2) @(negedge clk);
      start1 = 1'b1;
      start2 = 1'b1;
      repeat (2) @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_outputs", out1 == 21'd0 && out2 == 48'd0,
             $sformatf("%h/%h", out1, out2), "all zero");
      end

      // Nominal N=8 run
      launch1(s0);
      goto_neg(s0 + 33);
      drained("nominal_drained");

      // Same run with start pulses in RUN (cycle 3) and DONE (cycle 28)
      launch1(s0);
      goto_neg(s0 + 2);
      pulse1();
      goto_neg(s0 + 27);
      pulse1();
      goto_neg(s0 + 35);
      drained("extra_start_drained");

      // Reset asserted in cycle 12 for one cycle, fresh start in cycle 20
      launch1(s0);
      goto_neg(s0 + 10);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrun_reset_outputs", out1 == 21'd0 && out2 == 48'd0,
          $sformatf("%h/%h", out1, out2), "all zero");
      rd_q.delete();
      bf_q.delete();
      wr_q.delete();
      dn_q.delete();
      busy_lo = 1;
      busy_hi = 0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      goto_neg(s0 + 19);
      launch1(s1);
      goto_neg(s1 + 33);
      drained("restart_drained");

      // N=256, RAM_RD_LAT=2: reference built stage by stage from groups and offsets
      start2 = 1'b1;
      @(posedge clk);
      #1;
      s2 = edge_cnt;
      start2 = 1'b0;
      for (int l = 1; l <= 8; l++) begin
         half = 1 << (l - 1);
         grp  = 128 / half;
         idx  = 0;
         for (int g = 0; g < grp; g++) begin
            for (int j = 0; j < half; j++) begin
               int rc;
               int a;
               rc = s2 + (l - 1) * 134 + idx;
               a  = g * 2 * half + j;
               rd2_q.push_back('{rc, a, a + half, j * grp, l});
               wr2_q.push_back('{rc + 5, a, a + half, 0, 0});
               idx++;
            end
         end
      end
      dn2_q.push_back('{s2 + 1072, 0, 0, 0, 0});
      goto_neg(s2 + 1076);
      drained("n256_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
